// File: rtl/pipeline_regs_pkg.sv
// Shared types and defaults for the pipeline latch sequencing logic.
// The hazard controller drives each pipeline latch through a latch_ctrl_t
// and steps through the hzstate_t states while it waits on memory or drains
// the pipe after a HALT.
package pipeline_regs_pkg;

   // Controller states: normal flow, waiting on the data cache,
   // draining older instructions behind a HALT, and halted for good.
   typedef enum logic [1:0] {
      RUN        = 2'd0,
      DMEM_WAIT  = 2'd1,
      HALT_DRAIN = 2'd2,
      HALTED     = 2'd3
   } hzstate_t;

   // Per-latch control pair. When flush is set, the latch loads a bubble
   // and en is ignored.
   typedef struct packed {
      logic en;
      logic flush;
   } latch_ctrl_t;

   // Number of cycles between HALT decode and its retirement in WB.
   localparam int DRAIN_CYCLES_DEF = 3;

   // The three actions a latch can take in a cycle.
   localparam latch_ctrl_t LC_HOLD  = '{en: 1'b0, flush: 1'b0};
   localparam latch_ctrl_t LC_LOAD  = '{en: 1'b1, flush: 1'b0};
   localparam latch_ctrl_t LC_FLUSH = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare.
// A load sitting in DE whose destination matches a source register of the
// instruction in FD cannot be forwarded in time, so FD must wait a cycle.
// Register 0 is hardwired to zero and never creates a dependency.
module hazard_detect (
   input  logic       de_load,
   input  logic [4:0] de_wsel,
   input  logic [4:0] fd_rs,
   input  logic [4:0] fd_rt,
   input  logic       fd_uses_rt,
   output logic       load_use
);

   logic dest_valid;
   logic rs_match;
   logic rt_match;

   // Compare the DE destination against both FD source fields.
   always_comb begin
      dest_valid = de_load && (de_wsel != 5'd0);
      rs_match   = (de_wsel == fd_rs);
      rt_match   = fd_uses_rt && (de_wsel == fd_rt);
      load_use   = dest_valid && (rs_match || rt_match);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch sequencing controller.
// Decides each cycle whether the PC and the FD/DE/EM/MW latches load, hold
// or take a bubble, based on cache hits, load-use hazards, taken branches
// and HALT. It also runs the memory-wait / halt-drain state machine and
// counts the cycles in which fetch was frozen.
module pipeline_hazard_ctrl
   import pipeline_regs_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             em_memop,
   input  logic             de_load,
   input  logic [4:0]       de_wsel,
   input  logic [4:0]       fd_rs,
   input  logic [4:0]       fd_rt,
   input  logic             fd_uses_rt,
   input  logic             branch_taken,
   input  logic             halt_d,
   output logic             pc_en,
   output logic             fd_en,
   output logic             de_en,
   output logic             em_en,
   output logic             mw_en,
   output logic             fd_flush,
   output logic             de_flush,
   output logic             em_flush,
   output logic             mw_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   hzstate_t      state;
   hzstate_t      next_state;
   logic          ret_drain;
   logic          next_ret_drain;
   logic [DW-1:0] drain_cnt;
   logic [DW-1:0] next_drain_cnt;
   logic          ihit_pend;
   logic          ihit_eff;
   logic          dstall;
   logic          load_use;
   logic          freeze;

   logic          pc_en_c;
   latch_ctrl_t   fd_c;
   latch_ctrl_t   de_c;
   latch_ctrl_t   em_c;
   latch_ctrl_t   mw_c;

   hazard_detect u_hazard_detect (
      .de_load    (de_load),
      .de_wsel    (de_wsel),
      .fd_rs      (fd_rs),
      .fd_rt      (fd_rt),
      .fd_uses_rt (fd_uses_rt),
      .load_use   (load_use)
   );

   // An instruction word fetched while the front end was frozen is
   // remembered so it still counts as a hit once the freeze lifts.
   assign ihit_eff = ihit | ihit_pend;
   assign dstall   = em_memop && !dhit;

   // Per-cycle latch decisions and next-state selection, highest priority
   // first. A drain step counts down the instructions still ahead of HALT;
   // the last one retiring moves us to HALTED.
   always_comb begin
      pc_en_c        = 1'b0;
      fd_c           = LC_HOLD;
      de_c           = LC_HOLD;
      em_c           = LC_HOLD;
      mw_c           = LC_HOLD;
      freeze         = 1'b0;
      next_state     = state;
      next_ret_drain = ret_drain;
      next_drain_cnt = drain_cnt;

      if (state == HALTED) begin
         next_state = HALTED;
      end else if (dstall) begin
         mw_c   = LC_FLUSH;
         freeze = 1'b1;
         if (state != DMEM_WAIT) begin
            next_state     = DMEM_WAIT;
            next_ret_drain = (state == HALT_DRAIN);
         end
      end else if (state == DMEM_WAIT) begin
         pc_en_c        = 1'b1;
         fd_c           = LC_LOAD;
         de_c           = LC_LOAD;
         em_c           = LC_LOAD;
         mw_c           = LC_LOAD;
         next_ret_drain = 1'b0;
         if (ret_drain) begin
            if (drain_cnt <= DW'(1)) begin
               next_state     = HALTED;
               next_drain_cnt = '0;
            end else begin
               next_state     = HALT_DRAIN;
               next_drain_cnt = drain_cnt - DW'(1);
            end
         end else begin
            next_state = RUN;
         end
      end else if (state == HALT_DRAIN) begin
         fd_c = LC_FLUSH;
         de_c = LC_LOAD;
         em_c = LC_LOAD;
         mw_c = LC_LOAD;
         if (drain_cnt <= DW'(1)) begin
            next_state     = HALTED;
            next_drain_cnt = '0;
         end else begin
            next_drain_cnt = drain_cnt - DW'(1);
         end
      end else if (branch_taken) begin
         pc_en_c = 1'b1;
         fd_c    = LC_FLUSH;
         de_c    = LC_FLUSH;
         em_c    = LC_LOAD;
         mw_c    = LC_LOAD;
      end else if (halt_d) begin
         fd_c           = LC_FLUSH;
         de_c           = LC_LOAD;
         em_c           = LC_LOAD;
         mw_c           = LC_LOAD;
         next_state     = HALT_DRAIN;
         next_drain_cnt = DW'(DRAIN_CYCLES);
      end else if (load_use) begin
         de_c   = LC_FLUSH;
         em_c   = LC_LOAD;
         mw_c   = LC_LOAD;
         freeze = 1'b1;
      end else if (!ihit_eff) begin
         fd_c = LC_FLUSH;
         de_c = LC_LOAD;
         em_c = LC_LOAD;
         mw_c = LC_LOAD;
      end else begin
         pc_en_c = 1'b1;
         fd_c    = LC_LOAD;
         de_c    = LC_LOAD;
         em_c    = LC_LOAD;
         mw_c    = LC_LOAD;
      end
   end

   // While reset is asserted every latch is forced to a bubble so the pipe
   // comes up empty; otherwise the decoded controls go straight out.
   always_comb begin
      pc_en    = RST ? 1'b0 : pc_en_c;
      fd_en    = RST ? 1'b0 : fd_c.en;
      de_en    = RST ? 1'b0 : de_c.en;
      em_en    = RST ? 1'b0 : em_c.en;
      mw_en    = RST ? 1'b0 : mw_c.en;
      fd_flush = RST ? 1'b1 : fd_c.flush;
      de_flush = RST ? 1'b1 : de_c.flush;
      em_flush = RST ? 1'b1 : em_c.flush;
      mw_flush = RST ? 1'b1 : mw_c.flush;
      halt     = (state == HALTED);
   end

   // State machine registers: current state, the return-to-drain flag used
   // when a memory wait interrupts a drain, and the drain countdown.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= RUN;
         ret_drain <= 1'b0;
         drain_cnt <= '0;
      end else begin
         state     <= next_state;
         ret_drain <= next_ret_drain;
         drain_cnt <= next_drain_cnt;
      end
   end

   // Remember an instruction-cache hit that arrived while fetch was frozen
   // by a memory stall or load-use bubble; drop it once the PC advances.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ihit_pend <= 1'b0;
      end else if (pc_en_c) begin
         ihit_pend <= 1'b0;
      end else if (freeze && ihit) begin
         ihit_pend <= 1'b1;
      end
   end

   // Count cycles in which fetch did not advance, excluding the halted
   // state; the counter sticks at all-ones instead of wrapping.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt <= '0;
      end else if (!pc_en_c && (state != HALTED) && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl.
// The driver applies one input vector per cycle and queues the hand-derived
// response for that cycle; the monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 16;

   // Control vector order: {pc, fd_en, de_en, em_en, mw_en, fd_fl, de_fl, em_fl, mw_fl}
   localparam logic [8:0] RESETV  = 9'b0_0000_1111;
   localparam logic [8:0] ALL_RUN = 9'b1_1111_0000;
   localparam logic [8:0] LOADUSE = 9'b0_0011_0100;
   localparam logic [8:0] DSTALL  = 9'b0_0000_0001;
   localparam logic [8:0] BRANCH  = 9'b1_0011_1100;
   localparam logic [8:0] IMEM    = 9'b0_0111_1000;
   localparam logic [8:0] DRAIN   = 9'b0_0111_1000;
   localparam logic [8:0] HALTEDV = 9'b0_0000_0000;

   typedef struct {
      string            name;
      logic [8:0]       ctrl;
      logic             halt;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             CLK;
   logic             RST;
   logic             ihit;
   logic             dhit;
   logic             em_memop;
   logic             de_load;
   logic [4:0]       de_wsel;
   logic [4:0]       fd_rs;
   logic [4:0]       fd_rt;
   logic             fd_uses_rt;
   logic             branch_taken;
   logic             halt_d;
   logic             pc_en;
   logic             fd_en;
   logic             de_en;
   logic             em_en;
   logic             mw_en;
   logic             fd_flush;
   logic             de_flush;
   logic             em_flush;
   logic             mw_flush;
   logic             halt;
   logic [CNT_W-1:0] stall_cnt;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(3)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .ihit         (ihit),
      .dhit         (dhit),
      .em_memop     (em_memop),
      .de_load      (de_load),
      .de_wsel      (de_wsel),
      .fd_rs        (fd_rs),
      .fd_rt        (fd_rt),
      .fd_uses_rt   (fd_uses_rt),
      .branch_taken (branch_taken),
      .halt_d       (halt_d),
      .pc_en        (pc_en),
      .fd_en        (fd_en),
      .de_en        (de_en),
      .em_en        (em_en),
      .mw_en        (mw_en),
      .fd_flush     (fd_flush),
      .de_flush     (de_flush),
      .em_flush     (em_flush),
      .mw_flush     (mw_flush),
      .halt         (halt),
      .stall_cnt    (stall_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Compare the DUT outputs of the current cycle with one queued expectation.
   task automatic checkOutput(input exp_t e);
      logic [8:0] act;
      act = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, mw_flush};
      checks++;
      if (act !== e.ctrl) begin
         errors++;
         $display("[TB] FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
      end
      checks++;
      if (halt !== e.halt) begin
         errors++;
         $display("[TB] FAIL %s halt: got %b expected %b", e.name, halt, e.halt);
      end
      checks++;
      if (stall_cnt !== e.cnt) begin
         errors++;
         $display("[TB] FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and, if requested,
   // queue the response expected for that cycle.
   task automatic applyStimulus(input string nm, input logic r, input logic ih,
                                input logic dh, input logic mo, input logic dl,
                                input logic [4:0] ws, input logic [4:0] rs,
                                input logic [4:0] rt, input logic urt,
                                input logic br, input logic hd,
                                input logic [8:0] ec, input logic eh,
                                input logic [CNT_W-1:0] ecnt, input bit push);
      exp_t e;
      @(posedge CLK);
      #1;
      RST          = r;
      ihit         = ih;
      dhit         = dh;
      em_memop     = mo;
      de_load      = dl;
      de_wsel      = ws;
      fd_rs        = rs;
      fd_rt        = rt;
      fd_uses_rt   = urt;
      branch_taken = br;
      halt_d       = hd;
      if (push) begin
         e.name = nm;
         e.ctrl = ec;
         e.halt = eh;
         e.cnt  = ecnt;
         expq.push_back(e);
      end
   endtask

   // Monitor: the controller presents a response every cycle.
   initial begin
      forever begin
         @(negedge CLK);
         if (expq.size() > 0) checkOutput(expq.pop_front());
      end
   end

   // Directed stimulus with hand-derived responses.
   initial begin
      RST = 1'b1; ihit = 1'b1; dhit = 1'b0; em_memop = 1'b0; de_load = 1'b0;
      de_wsel = '0; fd_rs = '0; fd_rt = '0; fd_uses_rt = 1'b0;
      branch_taken = 1'b0; halt_d = 1'b0;

      applyStimulus("rst_hold0",        1,1,0,0,0, 0,0,0,0, 0,0, RESETV, 0, 0, 1);
      applyStimulus("rst_hold1",        1,1,0,0,0, 0,0,0,0, 0,0, RESETV, 0, 0, 1);
      applyStimulus("run_after_rst",    0,1,0,0,0, 0,0,0,0, 0,0, ALL_RUN,0, 0, 1);
      applyStimulus("run_idle",         0,1,0,0,0, 0,0,0,0, 0,0, ALL_RUN,0, 0, 1);
      applyStimulus("loaduse_rs",       0,1,0,0,1, 8,8,0,0, 0,0, LOADUSE,0, 0, 1);
      applyStimulus("after_loaduse",    0,1,0,0,0, 0,0,0,0, 0,0, ALL_RUN,0, 1, 1);
      applyStimulus("wsel_zero",        0,1,0,0,1, 0,0,0,0, 0,0, ALL_RUN,0, 1, 1);
      applyStimulus("rt_unused",        0,1,0,0,1, 9,3,9,0, 0,0, ALL_RUN,0, 1, 1);
      applyStimulus("loaduse_rt",       0,0,0,0,1, 9,3,9,1, 0,0, LOADUSE,0, 1, 1);
      applyStimulus("imem_nopend",      0,0,0,0,0, 0,0,0,0, 0,0, IMEM,   0, 2, 1);
      applyStimulus("imem_back",        0,1,0,0,0, 0,0,0,0, 0,0, ALL_RUN,0, 3, 1);
      applyStimulus("loaduse_ihit",     0,1,0,0,1, 8,8,0,0, 0,0, LOADUSE,0, 3, 1);
      applyStimulus("pend_used",        0,0,0,0,0, 0,0,0,0, 0,0, ALL_RUN,0, 4, 1);
      applyStimulus("pend_cleared",     0,0,0,0,0, 0,0,0,0, 0,0, IMEM,   0, 4, 1);
      applyStimulus("run_again",        0,1,0,0,0, 0,0,0,0, 0,0, ALL_RUN,0, 5, 1);
      applyStimulus("dstall1",          0,0,0,1,0, 0,0,0,0, 0,0, DSTALL, 0, 5, 1);
      applyStimulus("dstall2_ihit",     0,1,0,1,0, 0,0,0,0, 0,0, DSTALL, 0, 6, 1);
      applyStimulus("dstall3",          0,0,0,1,0, 0,0,0,0, 0,0, DSTALL, 0, 7, 1);
      applyStimulus("dstall4",          0,0,0,1,0, 0,0,0,0, 0,0, DSTALL, 0, 8, 1);
      applyStimulus("dmem_release",     0,0,1,1,0, 0,0,0,0, 0,0, ALL_RUN,0, 9, 1);
      applyStimulus("pend_gone",        0,0,0,0,0, 0,0,0,0, 0,0, IMEM,   0, 9, 1);
      applyStimulus("run_c21",          0,1,0,0,0, 0,0,0,0, 0,0, ALL_RUN,0,10, 1);
      applyStimulus("branch_loaduse",   0,1,0,0,1, 8,8,0,0, 1,0, BRANCH, 0,10, 1);
      applyStimulus("branch_halt",      0,0,0,0,0, 0,0,0,0, 1,1, BRANCH, 0,10, 1);
      applyStimulus("after_branch",     0,1,0,0,0, 0,0,0,0, 0,0, ALL_RUN,0,10, 1);
      applyStimulus("dstall_single",    0,0,0,1,0, 0,0,0,0, 0,0, DSTALL, 0,10, 1);
      applyStimulus("dhit_ihit",        0,1,1,1,0, 0,0,0,0, 0,0, ALL_RUN,0,11, 1);
      applyStimulus("no_pend",          0,0,0,0,0, 0,0,0,0, 0,0, IMEM,   0,11, 1);
      applyStimulus("run_c28",          0,1,0,0,0, 0,0,0,0, 0,0, ALL_RUN,0,12, 1);
      applyStimulus("halt_decode",      0,1,0,0,0, 0,0,0,0, 0,1, DRAIN,  0,12, 1);
      applyStimulus("drain_br_ignored", 0,1,0,0,0, 0,0,0,0, 1,0, DRAIN,  0,13, 1);
      applyStimulus("drain_dstall1",    0,1,0,1,0, 0,0,0,0, 0,0, DSTALL, 0,14, 1);
      applyStimulus("drain_dstall2",    0,1,0,1,0, 0,0,0,0, 0,0, DSTALL, 0,15, 1);
      applyStimulus("drain_dmem_rel",   0,1,1,1,0, 0,0,0,0, 0,0, ALL_RUN,0,16, 1);
      applyStimulus("drain_last",       0,1,0,0,0, 0,0,0,0, 0,0, DRAIN,  0,16, 1);
      applyStimulus("halted",           0,1,0,0,0, 0,0,0,0, 0,0, HALTEDV,1,17, 1);
      applyStimulus("halted_sticky",    0,1,0,1,0, 0,0,0,0, 1,1, HALTEDV,1,17, 1);
      applyStimulus("rst_from_halt",    1,1,0,0,0, 0,0,0,0, 0,0, RESETV, 0, 0, 1);
      applyStimulus("run_c38",          0,1,0,0,0, 0,0,0,0, 0,0, ALL_RUN,0, 0, 1);
      applyStimulus("halt2_decode",     0,1,0,0,0, 0,0,0,0, 0,1, DRAIN,  0, 0, 1);
      applyStimulus("halt2_drain_a",    0,1,0,0,0, 0,0,0,0, 0,0, DRAIN,  0, 1, 1);
      applyStimulus("halt2_drain_b",    0,1,0,0,0, 0,0,0,0, 0,0, DRAIN,  0, 2, 1);
      applyStimulus("halt2_drain_c",    0,1,0,0,0, 0,0,0,0, 0,0, DRAIN,  0, 3, 1);
      applyStimulus("halt2_halted",     0,1,0,0,0, 0,0,0,0, 0,0, HALTEDV,1, 4, 1);
      applyStimulus("halt2_sticky",     0,1,0,0,0, 0,0,0,0, 0,0, HALTEDV,1, 4, 1);
      applyStimulus("rst_c45",          1,1,0,0,0, 0,0,0,0, 0,0, RESETV, 0, 0, 1);
      applyStimulus("dstall_pre_rst",   0,1,0,1,0, 0,0,0,0, 0,0, DSTALL, 0, 0, 1);
      applyStimulus("rst_mid",          1,1,0,1,0, 0,0,0,0, 0,0, RESETV, 0, 0, 1);
      applyStimulus("sat_start",        0,0,0,0,0, 0,0,0,0, 0,0, IMEM,   0, 0, 1);
      for (int i = 0; i < 65540; i++) begin
         applyStimulus("sat_run",       0,0,0,0,0, 0,0,0,0, 0,0, IMEM,   0, 0, 0);
      end
      applyStimulus("sat_check",        0,0,0,0,0, 0,0,0,0, 0,0, IMEM,   0, 16'hFFFF, 1);

      repeat (3) @(posedge CLK);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_queue: got %0d pending expected 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
